hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the only clock; reset_n, when low, resets all state immediately regardless of clk.
REQ-002 FWD_EN, default 1, SHALL mean writeback-stage forwarding is present (1) or absent (0).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 i_rd_ir  input  16  instruction in the rf_read stage; its source registers are checked.
REQ-006 i_issue_valid  input  1  i_rd_ir advances into execute at this edge.
REQ-007 i_wb_valid  input  1  a valid instruction occupies writeback this cycle.
REQ-008 i_wb_ir  input  16  writeback-stage instruction.
REQ-009 i_flush  input  1  the execute-stage instruction is squashed at this edge.
REQ-010 i_flush_ir  input  16  the squashed execute-stage instruction.
REQ-011 o_stall  output  1  rf_read must hold; combinational.
REQ-012 o_busy  output  8  bit r set when register r has one or more outstanding writes; registered.
REQ-013 o_err  output  1  sticky protocol-violation flag; registered.

Function
REQ-014 Decode SHALL use opcode ir[3:0] (op.vh names), register-form bit ir[4]=0, Rx=ir[7:5], Ry=ir[10:8].
REQ-015 Destination SHALL be Rx for OP_MV_X, OP_ADD_X, OP_SUB_X, OP_LD and OP_MVHI; R7 for OP_CALL_X; all other opcodes have no destination.
REQ-016 Sources SHALL be: MV_X = Ry if register form; ADD_X, SUB_X, CMP_X = Rx, plus Ry if register form; LD = Ry; ST = Rx, Ry; MVHI = Rx; J_X, JN_X, JZ_X, CALL_X = Ry if register form; undefined opcodes have none.
REQ-017 Each register SHALL have a 2-bit pending counter cnt[r] in the range 0..3.
REQ-018 On an accepted issue (i_issue_valid=1 and o_stall=0) of an instruction with a destination d, cnt[d] SHALL be incremented at that edge.
REQ-019 On i_wb_valid=1 with a writeback instruction whose destination is d, cnt[d] SHALL be decremented at that edge.
REQ-020 On i_flush=1 with a flushed instruction whose destination is d, cnt[d] SHALL be decremented at that edge.
REQ-021 Increment and decrement events to the same register in one cycle SHALL net algebraically; the increment SHALL be applied before any saturation check.
REQ-022 A decrement that would take a counter below 0 SHALL hold it at 0 and set o_err.
REQ-023 An increment that would take a counter above 3 SHALL hold it at 3 and set o_err.
REQ-024 eff[r] SHALL equal cnt[r] minus 1 when FWD_EN=1, i_wb_valid=1 and the writeback destination equals r; otherwise eff[r] SHALL equal cnt[r].
REQ-025 o_stall SHALL be 1 iff any source of i_rd_ir has eff[source] != 0, independent of i_issue_valid.
REQ-026 i_issue_valid=1 while o_stall=1 SHALL NOT change any counter and SHALL set o_err.
REQ-027 o_busy[r] SHALL equal (cnt[r] != 0), taken from registered state.
REQ-028 o_err SHALL remain set until reset.
REQ-029 The stall decision SHALL have zero latency: counter updates become visible in o_stall and o_busy in the cycle after the edge.

Reset
REQ-030 While reset_n=0, all cnt[r] SHALL be 0, o_busy SHALL be 0x00 and o_err SHALL be 0; o_stall SHALL follow REQ-025 from the cleared state, i.e. 0.
REQ-031 Reset asserted mid-operation SHALL discard all outstanding writes without waiting for a clock edge.
REQ-032 The first edge after reset_n rises SHALL process events normally.

Verification
REQ-033 Scenario 1: issue ADD R2,R3 (register form); next cycle i_rd_ir = SUB R4,R2 with i_wb_valid=0 -> o_busy=0x04, o_stall=1.
REQ-034 Scenario 2: continue scenario 1 with the ADD in writeback, FWD_EN=1 -> o_stall=0; with FWD_EN=0 -> o_stall=1 until the edge after writeback, then o_busy=0x00.
REQ-035 Scenario 3: issue CALL_X and MV R7 back-to-back, then i_rd_ir = J R7 -> cnt[7]=2; o_stall stays 1 until both have retired (FWD_EN=1: clears while the second is in writeback).
REQ-036 Scenario 4: same-cycle issue of LD R1 and writeback of MV R1 with cnt[1]=1 -> cnt[1] stays 1, o_err=0.
REQ-037 Scenario 5: flush of ST, then flush of MV R5 with cnt[5]=0 -> ST changes nothing; MV R5 leaves cnt[5]=0 and sets o_err=1, which stays set; i_issue_valid=1 while o_stall=1 -> counters unchanged, o_err=1.
REQ-038 Scenario 6: set cnt[3]=2 and cnt[6]=1, then pull reset_n low between edges -> o_busy=0x00 and o_err=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register pending-write counters
// that drive the rf_read stall and the per-register busy flags.
module hazard_scoreboard #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] i_rd_ir,
  input  logic        i_issue_valid,
  input  logic        i_wb_valid,
  input  logic [15:0] i_wb_ir,
  input  logic        i_flush,
  input  logic [15:0] i_flush_ir,
  output logic        o_stall,
  output logic [7:0]  o_busy,
  output logic        o_err
);
  localparam logic [3:0] OP_MV_X   = 4'h0;
  localparam logic [3:0] OP_ADD_X  = 4'h1;
  localparam logic [3:0] OP_SUB_X  = 4'h2;
  localparam logic [3:0] OP_CMP_X  = 4'h3;
  localparam logic [3:0] OP_LD     = 4'h4;
  localparam logic [3:0] OP_ST     = 4'h5;
  localparam logic [3:0] OP_MVHI   = 4'h6;
  localparam logic [3:0] OP_J_X    = 4'h8;
  localparam logic [3:0] OP_JZ_X   = 4'h9;
  localparam logic [3:0] OP_JN_X   = 4'ha;
  localparam logic [3:0] OP_CALL_X = 4'hb;

  // {valid, reg}
  function automatic logic [3:0] dst_of(input logic [15:0] ir);
    logic [3:0] d;
    d = 4'b0;
    unique case (ir[3:0])
      OP_MV_X, OP_ADD_X, OP_SUB_X,
      OP_LD, OP_MVHI: d = {1'b1, ir[7:5]};
      OP_CALL_X:      d = 4'b1111;
      default:        d = 4'b0;
    endcase
    return d;
  endfunction

  // {v0, r0, v1, r1}
  function automatic logic [7:0] src_of(input logic [15:0] ir);
    logic       rf;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] s;
    rf = ~ir[4];
    rx = ir[7:5];
    ry = ir[10:8];
    s  = 8'b0;
    unique case (ir[3:0])
      OP_MV_X:  s = {4'b0, rf, ry};
      OP_ADD_X, OP_SUB_X,
      OP_CMP_X: s = {1'b1, rx, rf, ry};
      OP_LD:    s = {4'b0, 1'b1, ry};
      OP_ST:    s = {1'b1, rx, 1'b1, ry};
      OP_MVHI:  s = {1'b1, rx, 4'b0};
      OP_J_X, OP_JN_X, OP_JZ_X,
      OP_CALL_X: s = {4'b0, rf, ry};
      default:  s = 8'b0;
    endcase
    return s;
  endfunction

  logic [7:0][1:0] cnt_q, cnt_d;
  logic [7:0][3:0] sum;
  logic            err_q, err_d;
  logic [3:0]      rd_dst, wb_dst, fl_dst;
  logic [7:0]      rd_src;
  logic [7:0]      fwd_hit, eff_nz;
  logic            issue_ok;

  assign rd_dst = dst_of(i_rd_ir);
  assign wb_dst = dst_of(i_wb_ir);
  assign fl_dst = dst_of(i_flush_ir);
  assign rd_src = src_of(i_rd_ir);

  // eff != 0 means cnt differs from the forwarded amount
  always_comb begin
    fwd_hit = '0;
    eff_nz  = '0;
    for (int r = 0; r < 8; r++) begin
      fwd_hit[r] = FWD_EN && i_wb_valid
                && wb_dst == {1'b1, 3'(r)};
      eff_nz[r]  = cnt_q[r] != {1'b0, fwd_hit[r]};
    end
  end

  assign o_stall = (rd_src[7] && eff_nz[rd_src[6:4]])
                || (rd_src[3] && eff_nz[rd_src[2:0]]);
  assign issue_ok = i_issue_valid && !o_stall;

  // sum is biased by 2 so net -2..+1 stays unsigned
  always_comb begin
    err_d = err_q | (i_issue_valid & o_stall);
    cnt_d = cnt_q;
    sum   = '0;
    for (int r = 0; r < 8; r++) begin
      sum[r] = {2'b0, cnt_q[r]} + 4'd2
             + {3'b0, issue_ok && rd_dst == {1'b1, 3'(r)}}
             - {3'b0, i_wb_valid && wb_dst == {1'b1, 3'(r)}}
             - {3'b0, i_flush && fl_dst == {1'b1, 3'(r)}};
      if (sum[r] < 4'd2) begin
        cnt_d[r] = 2'd0;
        err_d    = 1'b1;
      end else if (sum[r] > 4'd5) begin
        cnt_d[r] = 2'd3;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = 2'(sum[r] - 4'd2);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    o_busy = '0;
    for (int r = 0; r < 8; r++) o_busy[r] = |cnt_q[r];
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic
// against a pending-count model, with and without forwarding.
module tb_hazard_scoreboard;
  localparam logic [3:0] OP_MV   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_MVHI = 4'h6;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JN   = 4'ha;
  localparam logic [3:0] OP_CALL = 4'hb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] rd_ir = '0, wb_ir = '0, fl_ir = '0;
  logic        iss = 1'b0, wbv = 1'b0, fl = 1'b0;
  logic        f1_stall, f1_err, f0_stall, f0_err;
  logic [7:0]  f1_busy, f0_busy;

  int checks = 0;
  int errors = 0;

  // model: index 0 has forwarding, index 1 does not
  int mc[2][8];
  bit me[2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.FWD_EN(1'b1)) dut_f1 (
    .clk(clk), .reset_n(reset_n), .i_rd_ir(rd_ir),
    .i_issue_valid(iss), .i_wb_valid(wbv), .i_wb_ir(wb_ir),
    .i_flush(fl), .i_flush_ir(fl_ir), .o_stall(f1_stall),
    .o_busy(f1_busy), .o_err(f1_err));

  hazard_scoreboard #(.FWD_EN(1'b0)) dut_f0 (
    .clk(clk), .reset_n(reset_n), .i_rd_ir(rd_ir),
    .i_issue_valid(iss), .i_wb_valid(wbv), .i_wb_ir(wb_ir),
    .i_flush(fl), .i_flush_ir(fl_ir), .o_stall(f0_stall),
    .o_busy(f0_busy), .o_err(f0_err));

  function automatic logic [15:0] enc(logic [3:0] op, logic imm,
                                      int rx, int ry);
    return {5'b0, 3'(ry), 3'(rx), imm, op};
  endfunction

  function automatic int dst_of(logic [15:0] ir);
    case (ir[3:0])
      OP_MV, OP_ADD, OP_SUB, OP_LD, OP_MVHI: return int'(ir[7:5]);
      OP_CALL: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic void src_of(input logic [15:0] ir,
                                 output int s0, output int s1);
    bit rf;
    int rx, ry;
    rf = !ir[4];
    rx = int'(ir[7:5]);
    ry = int'(ir[10:8]);
    s0 = -1;
    s1 = -1;
    case (ir[3:0])
      OP_MV: if (rf) s1 = ry;
      OP_ADD, OP_SUB, OP_CMP: begin
        s0 = rx;
        if (rf) s1 = ry;
      end
      OP_LD: s1 = ry;
      OP_ST: begin s0 = rx; s1 = ry; end
      OP_MVHI: s0 = rx;
      OP_J, OP_JN, OP_JZ, OP_CALL: if (rf) s1 = ry;
      default: ;
    endcase
  endfunction

  function automatic int eff(int k, int s);
    int e;
    if (s < 0) return 0;
    e = mc[k][s];
    if (k == 0 && wbv && dst_of(wb_ir) == s) e = e - 1;
    return e;
  endfunction

  function automatic bit m_stall(int k);
    int s0, s1;
    src_of(rd_ir, s0, s1);
    return eff(k, s0) != 0 || eff(k, s1) != 0;
  endfunction

  function automatic logic [7:0] m_busy(int k);
    logic [7:0] b;
    for (int r = 0; r < 8; r++) b[r] = mc[k][r] != 0;
    return b;
  endfunction

  function automatic void chk(string nm, logic [7:0] act,
                              logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endfunction

  always @(negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      me[k] = 1'b0;
      for (int r = 0; r < 8; r++) mc[k][r] = 0;
    end
  end

  always @(posedge clk) begin : model_upd
    int nx[8];
    int n;
    bit stl;
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        stl = m_stall(k);
        if (iss && stl) me[k] = 1'b1;
        for (int r = 0; r < 8; r++) begin
          n = mc[k][r];
          if (iss && !stl && dst_of(rd_ir) == r) n++;
          if (wbv && dst_of(wb_ir) == r) n--;
          if (fl && dst_of(fl_ir) == r) n--;
          if (n < 0) begin n = 0; me[k] = 1'b1; end
          if (n > 3) begin n = 3; me[k] = 1'b1; end
          nx[r] = n;
        end
        for (int r = 0; r < 8; r++) mc[k][r] = nx[r];
      end
    end
  end

  always @(negedge clk) begin
    chk("stall_fwd", 8'(f1_stall), 8'(m_stall(0)));
    chk("busy_fwd", f1_busy, m_busy(0));
    chk("err_fwd", 8'(f1_err), 8'(me[0]));
    chk("stall_nofwd", 8'(f0_stall), 8'(m_stall(1)));
    chk("busy_nofwd", f0_busy, m_busy(1));
    chk("err_nofwd", 8'(f0_err), 8'(me[1]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_ir();
    logic [15:0] v;
    v = 16'($urandom);
    v[7:5]  = 3'($urandom_range(0, 3));
    v[10:8] = 3'($urandom_range(0, 7));
    return v;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", f1_busy, 8'h00);
    chk("rst_err", 8'(f1_err), 8'h00);
    reset_n = 1'b1;

    // dependent SUB behind ADD R2
    rd_ir = enc(OP_ADD, 1'b0, 2, 3);
    iss = 1'b1;
    tick();
    iss = 1'b0;
    rd_ir = enc(OP_SUB, 1'b0, 4, 2);
    #1;
    chk("s1_busy", f1_busy, 8'h04);
    chk("s1_stall", 8'(f1_stall), 8'h01);
    chk("s1_stall_nf", 8'(f0_stall), 8'h01);
    wbv = 1'b1;
    wb_ir = enc(OP_ADD, 1'b0, 2, 3);
    #1;
    chk("s2_fwd", 8'(f1_stall), 8'h00);
    chk("s2_nofwd", 8'(f0_stall), 8'h01);
    tick();
    wbv = 1'b0;
    #1;
    chk("s2_after", 8'(f0_stall), 8'h00);
    chk("s2_busy", f0_busy, 8'h00);

    // two writers of R7, then J R7
    rd_ir = enc(OP_CALL, 1'b0, 0, 1);
    iss = 1'b1;
    tick();
    rd_ir = enc(OP_MV, 1'b0, 7, 1);
    tick();
    iss = 1'b0;
    rd_ir = enc(OP_J, 1'b0, 0, 7);
    #1;
    chk("s3_busy", f1_busy, 8'h80);
    chk("s3_stall", 8'(f1_stall), 8'h01);
    wbv = 1'b1;
    wb_ir = enc(OP_CALL, 1'b0, 0, 1);
    #1;
    chk("s3_cnt2", 8'(f1_stall), 8'h01);
    tick();
    wb_ir = enc(OP_MV, 1'b0, 7, 1);
    #1;
    chk("s3_fwd", 8'(f1_stall), 8'h00);
    chk("s3_nofwd", 8'(f0_stall), 8'h01);
    tick();
    wbv = 1'b0;
    #1;
    chk("s3_done", 8'(f0_stall), 8'h00);

    // issue and writeback to R1 in one cycle
    rd_ir = enc(OP_MV, 1'b0, 1, 0);
    iss = 1'b1;
    tick();
    rd_ir = enc(OP_LD, 1'b0, 1, 2);
    wbv = 1'b1;
    wb_ir = enc(OP_MV, 1'b0, 1, 0);
    tick();
    iss = 1'b0;
    wbv = 1'b0;
    #1;
    chk("s4_busy", f1_busy, 8'h02);
    chk("s4_err", 8'(f1_err), 8'h00);
    wbv = 1'b1;
    tick();
    wbv = 1'b0;

    // flushes, then issue while stalled
    fl = 1'b1;
    fl_ir = enc(OP_ST, 1'b0, 1, 2);
    tick();
    chk("s5_st_busy", f1_busy, 8'h00);
    chk("s5_st_err", 8'(f1_err), 8'h00);
    fl_ir = enc(OP_MV, 1'b0, 5, 0);
    tick();
    fl = 1'b0;
    #1;
    chk("s5_under", 8'(f1_err), 8'h01);
    rd_ir = enc(OP_MV, 1'b0, 6, 0);
    iss = 1'b1;
    tick();
    rd_ir = enc(OP_ADD, 1'b0, 6, 0);
    #1;
    chk("s5_stall", 8'(f1_stall), 8'h01);
    tick();
    iss = 1'b0;
    #1;
    chk("s5_hold", f1_busy, 8'h40);
    repeat (3) tick();
    chk("s5_sticky", 8'(f1_err), 8'h01);

    // asynchronous reset between edges
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    rd_ir = enc(OP_MV, 1'b0, 3, 0);
    iss = 1'b1;
    tick();
    tick();
    rd_ir = enc(OP_MV, 1'b0, 6, 0);
    tick();
    iss = 1'b0;
    fl = 1'b1;
    fl_ir = enc(OP_MV, 1'b0, 5, 0);
    tick();
    fl = 1'b0;
    #1;
    chk("s6_pre_busy", f1_busy, 8'h48);
    chk("s6_pre_err", 8'(f1_err), 8'h01);
    reset_n = 1'b0;
    #1;
    chk("s6_busy", f1_busy, 8'h00);
    chk("s6_err", 8'(f1_err), 8'h00);
    chk("s6_busy_nf", f0_busy, 8'h00);
    tick();
    reset_n = 1'b1;

    repeat (800) begin
      tick();
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
      rd_ir = rnd_ir();
      wb_ir = rnd_ir();
      fl_ir = rnd_ir();
      iss = $urandom_range(0, 99) < 60;
      wbv = $urandom_range(0, 99) < 35;
      fl  = $urandom_range(0, 99) < 8;
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
